cpu_retire_tracer: RTL

- Sits directly downstream of the gp_cpu writeback/memory stages and consumes their per-instruction retirement signals.
- Classifies each qualified retirement, tags it with an instruction number and PC, and pushes one record into an on-chip FIFO.
- Keeps free-running cycle and instruction counters and freezes once the halt record is captured.
- A debug host or scan port drains the FIFO over a valid/ready handshake, giving an in-silicon equivalent of the simulation trace.

---
 rtl/cpu_retire_tracer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_retire_tracer.sv
// cpu_retire_tracer: classifies each qualified retirement from the gp_cpu
// writeback/memory stages into a trace record, queues it in a show-ahead
// FIFO drained over valid/ready, and keeps free-running cycle/instruction
// counters that freeze once the halt record has been captured.
module cpu_retire_tracer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wb_valid,
  input  logic [15:0]      wb_pc,
  input  logic             wb_reg_write,
  input  logic [2:0]       wb_rd,
  input  logic [15:0]      wb_write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data,
  input  logic             halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       rec_type,
  output logic             rec_ld,
  output logic [CNT_W-1:0] rec_inum,
  output logic [15:0]      rec_pc,
  output logic [2:0]       rec_reg,
  output logic [15:0]      rec_addr,
  output logic [15:0]      rec_value,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic             halted,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  // Pointers wrap naturally because DEPTH is a power of two; the
  // occupancy counter needs one extra state to tell full from empty.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int REC_W = 2 + 1 + CNT_W + 16 + 3 + 16 + 16;

  localparam logic [1:0] TYPE_OTHER = 2'd0;
  localparam logic [1:0] TYPE_REG   = 2'd1;
  localparam logic [1:0] TYPE_STORE = 2'd2;
  localparam logic [1:0] TYPE_HALT  = 2'd3;

  // State flops
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic             halted_q, halted_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;

  // Record storage (no reset: contents are only visible while occupied)
  logic [REC_W-1:0] mem_q [DEPTH];

  // Control
  logic             active;
  logic             capture;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Incoming record fields
  logic [1:0]       in_type;
  logic             in_ld;
  logic [2:0]       in_reg;
  logic [15:0]      in_addr;
  logic [15:0]      in_value;
  logic [REC_W-1:0] in_rec;

  // Head record fields
  logic [1:0]       hd_type;
  logic             hd_ld;
  logic [CNT_W-1:0] hd_inum;
  logic [15:0]      hd_pc;
  logic [2:0]       hd_reg;
  logic [15:0]      hd_addr;
  logic [15:0]      hd_value;

  // Qualify the cycle and decide push / pop / drop for the FIFO.
  always_comb begin
    active    = ~rst & en & ~halted_q;
    capture   = active & wb_valid;
    full      = (occ_q == OCC_W'(DEPTH));
    out_valid = (occ_q != '0);
    pop       = out_valid & out_ready;
    push      = capture & (~full | pop);
    drop      = capture & ~push;
  end

  // Classify the retirement; fields that do not apply to the class stay 0.
  always_comb begin
    in_type  = TYPE_OTHER;
    in_ld    = 1'b0;
    in_reg   = 3'd0;
    in_addr  = 16'd0;
    in_value = 16'd0;
    if (halt) begin
      in_type = TYPE_HALT;
    end else if (wb_reg_write) begin
      in_type  = TYPE_REG;
      in_ld    = mem_read;
      in_reg   = wb_rd;
      in_value = wb_write_data;
      if (mem_read) begin
        in_addr = mem_addr;
      end
    end else if (mem_write) begin
      in_type  = TYPE_STORE;
      in_addr  = mem_addr;
      in_value = mem_data;
    end
    // inum is the instruction count before this cycle's increment
    in_rec = {in_type, in_ld, inst_q, wb_pc, in_reg, in_addr, in_value};
  end

  // Next-state for pointers, occupancy, counters and sticky flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    cycle_d    = cycle_q;
    inst_d     = inst_q;
    halted_d   = halted_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (active) begin
      cycle_d = cycle_q + CNT_W'(1);
    end
    if (capture) begin
      inst_d = inst_q + CNT_W'(1);
      // halt is captured even if its record has to be dropped
      if (halt) begin
        halted_d = 1'b1;
      end
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // Control/counter registers; reset empties the FIFO at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      cycle_q    <= '0;
      inst_q     <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      cycle_q    <= cycle_d;
      inst_q     <= inst_d;
      halted_q   <= halted_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Record storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_rec;
    end
  end

  // Show-ahead head: the record at the read pointer, zeroed when empty so
  // the outputs read 0 out of reset and between records.
  always_comb begin
    {hd_type, hd_ld, hd_inum, hd_pc, hd_reg, hd_addr, hd_value} = mem_q[rd_ptr_q];
    rec_type  = out_valid ? hd_type  : 2'd0;
    rec_ld    = out_valid ? hd_ld    : 1'b0;
    rec_inum  = out_valid ? hd_inum  : '0;
    rec_pc    = out_valid ? hd_pc    : 16'd0;
    rec_reg   = out_valid ? hd_reg   : 3'd0;
    rec_addr  = out_valid ? hd_addr  : 16'd0;
    rec_value = out_valid ? hd_value : 16'd0;
  end

  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign halted      = halted_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_q;

endmodule
